// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit with byte-lane alignment,
//               load sign/zero extension, alignment checks and bus timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int XLEN    = 64,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [2:0]          req_type,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic [1:0]          resp_err,
    output logic                stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_be,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_ack,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int         c_BEW      = XLEN / 8;
    localparam int         c_OFFW     = $clog2(c_BEW);
    localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BUSY = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    localparam logic [1:0] c_ERR_OK    = 2'b00;
    localparam logic [1:0] c_ERR_ALIGN = 2'b01;
    localparam logic [1:0] c_ERR_TMO   = 2'b10;
    localparam logic [1:0] c_ERR_TYPE  = 2'b11;

    logic [1:0]          r_state;
    logic [7:0]          r_cnt;
    logic [2:0]          r_type;
    logic [c_OFFW-1:0]   r_off;
    logic                r_write;
    logic                r_reqReady;
    logic                r_stall;
    logic                r_respValid;
    logic [XLEN-1:0]     r_respRdata;
    logic [1:0]          r_respErr;
    logic                r_memReq;
    logic                r_memWe;
    logic [ADDR_W-1:0]   r_memAddr;
    logic [c_BEW-1:0]    r_memBe;
    logic [XLEN-1:0]     r_memWdata;

    logic [c_OFFW-1:0]   w_off;
    logic                w_illegal;
    logic                w_misaligned;
    logic [7:0]          w_beBase;
    logic [c_BEW-1:0]    w_be;
    logic [XLEN-1:0]     w_wdata;
    logic [ADDR_W-1:0]   w_alignedAddr;
    logic [63:0]         w_lane;
    logic                w_sx;
    logic [63:0]         w_ext;

    assign w_off         = req_addr[c_OFFW-1:0];
    assign w_illegal     = (req_type == 3'b111) ||
                           ((XLEN == 32) && ((req_type == 3'b011) || (req_type == 3'b110)));
    assign w_be          = w_beBase[c_BEW-1:0] << w_off;
    assign w_wdata       = req_wdata << {w_off, 3'b000};
    assign w_alignedAddr = {req_addr[ADDR_W-1:c_OFFW], {c_OFFW{1'b0}}};

    // Access size comes from funct3[1:0]; funct3[2] marks the unsigned loads.
    always_comb begin
        w_misaligned = 1'b0;
        w_beBase     = 8'h01;
        case (req_type[1:0])
            2'd1: begin w_misaligned = req_addr[0];      w_beBase = 8'h03; end
            2'd2: begin w_misaligned = |req_addr[1:0];   w_beBase = 8'h0F; end
            2'd3: begin w_misaligned = |req_addr[2:0];   w_beBase = 8'hFF; end
            default: begin w_misaligned = 1'b0;          w_beBase = 8'h01; end
        endcase
    end

    assign w_lane = 64'(mem_rdata >> {r_off, 3'b000});
    assign w_sx   = ~r_type[2];

    always_comb begin
        w_ext = w_lane;
        case (r_type[1:0])
            2'd0:    w_ext = {{56{w_sx & w_lane[7]}},  w_lane[7:0]};
            2'd1:    w_ext = {{48{w_sx & w_lane[15]}}, w_lane[15:0]};
            2'd2:    w_ext = {{32{w_sx & w_lane[31]}}, w_lane[31:0]};
            default: w_ext = w_lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_cnt       <= '0;
            r_type      <= '0;
            r_off       <= '0;
            r_write     <= 1'b0;
            r_reqReady  <= 1'b0;
            r_stall     <= 1'b0;
            r_respValid <= 1'b0;
            r_respRdata <= '0;
            r_respErr   <= c_ERR_OK;
            r_memReq    <= 1'b0;
            r_memWe     <= 1'b0;
            r_memAddr   <= '0;
            r_memBe     <= '0;
            r_memWdata  <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    r_respValid <= 1'b0;
                    r_reqReady  <= 1'b1;
                    r_stall     <= 1'b0;
                    if (req_valid && r_reqReady) begin
                        r_type     <= req_type;
                        r_off      <= w_off;
                        r_write    <= req_write;
                        r_cnt      <= '0;
                        r_reqReady <= 1'b0;
                        r_stall    <= 1'b1;
                        if (w_illegal || w_misaligned) begin
                            r_state     <= c_RESP;
                            r_respValid <= 1'b1;
                            r_respRdata <= '0;
                            r_respErr   <= w_illegal ? c_ERR_TYPE : c_ERR_ALIGN;
                        end else begin
                            r_state    <= c_BUSY;
                            r_memReq   <= 1'b1;
                            r_memWe    <= req_write;
                            r_memAddr  <= w_alignedAddr;
                            r_memBe    <= w_be;
                            r_memWdata <= w_wdata;
                        end
                    end
                end
                c_BUSY: begin
                    // An ack on the final timeout cycle still completes normally.
                    if (mem_ack || (r_cnt == c_TMO_LAST)) begin
                        r_state     <= c_RESP;
                        r_respValid <= 1'b1;
                        r_respErr   <= mem_ack ? c_ERR_OK : c_ERR_TMO;
                        r_respRdata <= (mem_ack && !r_write) ? w_ext[XLEN-1:0] : '0;
                        r_memReq    <= 1'b0;
                        r_memWe     <= 1'b0;
                        r_memAddr   <= '0;
                        r_memBe     <= '0;
                        r_memWdata  <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                c_RESP: begin
                    r_state     <= c_IDLE;
                    r_respValid <= 1'b0;
                    r_reqReady  <= 1'b1;
                    r_stall     <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = r_reqReady;
    assign stall      = r_stall;
    assign resp_valid = r_respValid;
    assign resp_rdata = r_respRdata;
    assign resp_err   = r_respErr;
    assign mem_req    = r_memReq;
    assign mem_we     = r_memWe;
    assign mem_addr   = r_memAddr;
    assign mem_be     = r_memBe;
    assign mem_wdata  = r_memWdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit (64-bit with
//               short timeout, plus a 32-bit instance for type legality).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    int          checks;
    int          errors;

    // 64-bit instance, TIMEOUT = 4
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_type;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic [1:0]  resp_err;
    logic        stall, mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr;
    logic [7:0]  mem_be;
    logic [63:0] mem_wdata, mem_rdata;

    // 32-bit instance
    logic        n_req_valid, n_req_ready, n_req_write;
    logic [2:0]  n_req_type;
    logic [31:0] n_req_addr;
    logic [31:0] n_req_wdata;
    logic        n_resp_valid;
    logic [31:0] n_resp_rdata;
    logic [1:0]  n_resp_err;
    logic        n_stall, n_mem_req, n_mem_we, n_mem_ack;
    logic [31:0] n_mem_addr;
    logic [3:0]  n_mem_be;
    logic [31:0] n_mem_wdata, n_mem_rdata;

    load_store_unit #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) u_dut64 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.XLEN(32), .ADDR_W(32), .TIMEOUT(8)) u_dut32 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(n_req_valid), .req_ready(n_req_ready), .req_write(n_req_write),
        .req_type(n_req_type), .req_addr(n_req_addr), .req_wdata(n_req_wdata),
        .resp_valid(n_resp_valid), .resp_rdata(n_resp_rdata), .resp_err(n_resp_err),
        .stall(n_stall), .mem_req(n_mem_req), .mem_we(n_mem_we), .mem_addr(n_mem_addr),
        .mem_be(n_mem_be), .mem_wdata(n_mem_wdata), .mem_ack(n_mem_ack), .mem_rdata(n_mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic wr, input logic [2:0] t, input logic [31:0] a,
                         input logic [63:0] wd);
        req_valid = 1'b1;
        req_write = wr;
        req_type  = t;
        req_addr  = a;
        req_wdata = wd;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        req_valid = 0; req_write = 0; req_type = 0; req_addr = 0; req_wdata = 0;
        mem_ack = 0; mem_rdata = 0;
        n_req_valid = 0; n_req_write = 0; n_req_type = 0; n_req_addr = 0; n_req_wdata = 0;
        n_mem_ack = 0; n_mem_rdata = 0;

        // Reset state
        step(); step();
        chk("rst_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", req_ready, 1);
        chk("post_rst_stall", stall, 0);

        // lb at 0x1003, three wait cycles; ack lands on the timeout cycle
        issue(1'b0, 3'b000, 32'h1003, 64'h0);
        step();
        chk("lb_mem_req", mem_req, 1);
        chk("lb_mem_be", mem_be, 8'h08);
        chk("lb_mem_addr", mem_addr, 32'h1000);
        chk("lb_mem_we", mem_we, 0);
        chk("lb_stall", stall, 1);
        chk("lb_ready", req_ready, 0);
        issue(1'b1, 3'b010, 32'h7777, 64'h1234);
        step();
        chk("busy_ignore_addr", mem_addr, 32'h1000);
        chk("busy_ignore_be", mem_be, 8'h08);
        req_valid = 1'b0;
        step();
        chk("lb_wait3_req", mem_req, 1);
        chk("lb_wait3_valid", resp_valid, 0);
        step();
        chk("lb_wait4_req", mem_req, 1);
        mem_ack = 1'b1;
        mem_rdata = 64'h0000_0000_8000_0000;
        step();
        chk("lb_resp_valid", resp_valid, 1);
        chk("lb_resp_rdata", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_resp_err", resp_err, 2'b00);
        chk("lb_mem_req_drop", mem_req, 0);
        mem_ack = 1'b0;
        step();
        chk("lb_resp_end", resp_valid, 0);
        chk("lb_ready_again", req_ready, 1);

        // sh at 0x2006, zero-wait ack
        issue(1'b1, 3'b001, 32'h2006, 64'hABCD);
        step();
        req_valid = 1'b0;
        chk("sh_mem_addr", mem_addr, 32'h2000);
        chk("sh_mem_be", mem_be, 8'hC0);
        chk("sh_mem_wdata", mem_wdata, 64'hABCD_0000_0000_0000);
        chk("sh_mem_we", mem_we, 1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("sh_resp_valid", resp_valid, 1);
        chk("sh_resp_rdata", resp_rdata, 0);
        chk("sh_resp_err", resp_err, 2'b00);
        step();

        // lw at 0x3002: misaligned, no memory access
        issue(1'b0, 3'b010, 32'h3002, 64'h0);
        step();
        req_valid = 1'b0;
        chk("mis_resp_valid", resp_valid, 1);
        chk("mis_resp_err", resp_err, 2'b01);
        chk("mis_mem_req", mem_req, 0);
        step();
        chk("mis_resp_end", resp_valid, 0);
        chk("mis_mem_req2", mem_req, 0);

        // lw at 0x4000 with no ack: four cycles of mem_req then timeout
        issue(1'b0, 3'b010, 32'h4000, 64'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            req_valid = 1'b0;
            chk("tmo_mem_req", mem_req, 1);
        end
        step();
        chk("tmo_resp_valid", resp_valid, 1);
        chk("tmo_resp_err", resp_err, 2'b10);
        chk("tmo_mem_req_drop", mem_req, 0);
        step();

        // lwu and lw at 0x4004
        issue(1'b0, 3'b110, 32'h4004, 64'h0);
        step();
        req_valid = 1'b0;
        chk("lwu_mem_be", mem_be, 8'hF0);
        mem_ack = 1'b1;
        mem_rdata = 64'h8765_4321_0000_0000;
        step();
        mem_ack = 1'b0;
        chk("lwu_resp_rdata", resp_rdata, 64'h0000_0000_8765_4321);
        step();
        issue(1'b0, 3'b010, 32'h4004, 64'h0);
        step();
        req_valid = 1'b0;
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("lw_resp_rdata", resp_rdata, 64'hFFFF_FFFF_8765_4321);
        step();

        // Illegal type 111
        issue(1'b0, 3'b111, 32'h0, 64'h0);
        step();
        req_valid = 1'b0;
        chk("ill_resp_valid", resp_valid, 1);
        chk("ill_resp_err", resp_err, 2'b11);
        chk("ill_mem_req", mem_req, 0);
        step();

        // Reset during the second BUSY cycle, then a stray ack
        issue(1'b0, 3'b000, 32'h8000, 64'h0);
        step();
        req_valid = 1'b0;
        chk("abort_busy1", mem_req, 1);
        step();
        rst_n = 1'b0;
        step();
        chk("abort_mem_req", mem_req, 0);
        chk("abort_ready", req_ready, 0);
        chk("abort_resp_valid", resp_valid, 0);
        rst_n = 1'b1;
        mem_ack = 1'b1;
        step();
        chk("abort_ready_after", req_ready, 1);
        chk("abort_no_resp", resp_valid, 0);
        step();
        chk("abort_no_resp2", resp_valid, 0);
        chk("abort_mem_req2", mem_req, 0);
        mem_ack = 1'b0;
        step();

        // 32-bit instance: ld and wu are illegal, lbu is legal
        n_req_valid = 1'b1; n_req_type = 3'b011; n_req_addr = 32'h0;
        step();
        n_req_valid = 1'b0;
        chk("n32_ld_valid", n_resp_valid, 1);
        chk("n32_ld_err", n_resp_err, 2'b11);
        step();
        n_req_valid = 1'b1; n_req_type = 3'b110; n_req_addr = 32'h0;
        step();
        n_req_valid = 1'b0;
        chk("n32_wu_err", n_resp_err, 2'b11);
        step();
        n_req_valid = 1'b1; n_req_type = 3'b100; n_req_addr = 32'h102;
        step();
        n_req_valid = 1'b0;
        chk("n32_lbu_mem_addr", n_mem_addr, 32'h100);
        chk("n32_lbu_mem_be", n_mem_be, 4'h4);
        n_mem_ack = 1'b1;
        n_mem_rdata = 32'h00AB_0000;
        step();
        n_mem_ack = 1'b0;
        chk("n32_lbu_valid", n_resp_valid, 1);
        chk("n32_lbu_rdata", n_resp_rdata, 32'h0000_00AB);
        chk("n32_lbu_err", n_resp_err, 2'b00);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
